// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM states and default operand width.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = 6;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Core-side bundle for the multiply/divide unit: decode inputs, stall and
// HI/LO results.
interface mdu_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mf_req;
    logic             stall;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mf_req,
        input  stall, busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, mf_req,
        output stall, busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// One radix-2 step: shift-add multiply or restoring-divide subtract-shift,
// operating on a {acc_hi, acc_lo} pair against a fixed operand.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] sub;
    logic             ge;

    always_comb begin
        sum     = '0;
        shifted = '0;
        sub     = '0;
        ge      = 1'b0;
        next_hi = acc_hi;
        next_lo = acc_lo;
        if (is_div) begin
            // Remainder stays below the divisor, so the shifted value fits W+1 bits
            // and the low W bits of the difference are exact when ge is set.
            shifted = {acc_hi, acc_lo[WIDTH-1]};
            ge      = shifted >= {1'b0, opnd};
            sub     = shifted[WIDTH-1:0] - opnd;
            next_hi = ge ? sub : shifted[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], ge};
        end else begin
            sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; stalls the core only
// when it touches HI/LO or issues another mult/div while an op is in flight.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);

    mdu_state_e       state_reg, state_next;
    mdu_op_e          op_reg, op_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] opnd_reg, opnd_next;
    logic [WIDTH-1:0] acc_hi_reg, acc_hi_next;
    logic [WIDTH-1:0] acc_lo_reg, acc_lo_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             qsign_reg, qsign_next;
    logic             rsign_reg, rsign_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic             dbz_reg, dbz_next;

    logic               is_div;
    logic               is_signed;
    logic               accept;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   iter_hi;
    logic [WIDTH-1:0]   iter_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign is_div    = op_is_div(op_reg);
    assign is_signed = op_is_signed(op_reg);
    assign accept    = bus.start && (state_reg == ST_IDLE || state_reg == ST_DONE);

    assign abs_a = (is_signed && a_reg[WIDTH-1]) ? -a_reg : a_reg;
    assign abs_b = (is_signed && b_reg[WIDTH-1]) ? -b_reg : b_reg;

    // Sign correction on the magnitude result; the most-negative/-1 divide
    // wraps back to itself here without any special handling.
    assign prod_fix = qsign_reg ? -{acc_hi_reg, acc_lo_reg} : {acc_hi_reg, acc_lo_reg};
    assign quo_fix  = qsign_reg ? -acc_lo_reg : acc_lo_reg;
    assign rem_fix  = rsign_reg ? -acc_hi_reg : acc_hi_reg;

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div  (is_div),
        .acc_hi  (acc_hi_reg),
        .acc_lo  (acc_lo_reg),
        .opnd    (opnd_reg),
        .next_hi (iter_hi),
        .next_lo (iter_lo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_reg     <= MDU_MULTU;
            a_reg      <= '0;
            b_reg      <= '0;
            opnd_reg   <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            cnt_reg    <= '0;
            qsign_reg  <= 1'b0;
            rsign_reg  <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            dbz_reg    <= 1'b0;
        end else begin
            op_reg     <= op_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            opnd_reg   <= opnd_next;
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            cnt_reg    <= cnt_next;
            qsign_reg  <= qsign_next;
            rsign_reg  <= rsign_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            dbz_reg    <= dbz_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        opnd_next   = opnd_reg;
        acc_hi_next = acc_hi_reg;
        acc_lo_next = acc_lo_reg;
        cnt_next    = cnt_reg;
        qsign_next  = qsign_reg;
        rsign_next  = rsign_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        dbz_next    = dbz_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_next = ST_PREP;
                    op_next    = mdu_op_e'(bus.op);
                    a_next     = bus.a;
                    b_next     = bus.b;
                    dbz_next   = 1'b0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_PREP: begin
                if (is_div && b_reg == '0) begin
                    dbz_next   = 1'b1;
                    hi_next    = a_reg;
                    lo_next    = '1;
                    state_next = ST_DONE;
                end else begin
                    qsign_next  = is_signed && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                    rsign_next  = is_signed && a_reg[WIDTH-1];
                    // Divide shifts the dividend out of acc_lo; multiply shifts
                    // the multiplier out of acc_lo.
                    acc_hi_next = '0;
                    acc_lo_next = is_div ? abs_a : abs_b;
                    opnd_next   = is_div ? abs_b : abs_a;
                    cnt_next    = '0;
                    state_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_hi_next = iter_hi;
                acc_lo_next = iter_lo;
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                if (is_div) begin
                    hi_next = rem_fix;
                    lo_next = quo_fix;
                end else begin
                    hi_next = prod_fix[2*WIDTH-1:WIDTH];
                    lo_next = prod_fix[WIDTH-1:0];
                end
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.busy        = (state_reg == ST_PREP) || (state_reg == ST_RUN) || (state_reg == ST_FIX);
    assign bus.done        = (state_reg == ST_DONE);
    assign bus.stall       = bus.busy && (bus.mf_req || bus.start);
    assign bus.div_by_zero = dbz_reg;
    assign bus.hi          = hi_reg;
    assign bus.lo          = lo_reg;

endmodule
